// File: rtl/ifetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: FSM encodings and default sizes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ifetch_queue_pkg;

  // Fetch FSM encodings
  localparam logic [1:0] IFQ_IDLE    = 2'd0;
  localparam logic [1:0] IFQ_FETCH   = 2'd1;
  localparam logic [1:0] IFQ_DISCARD = 2'd2;

  // Default geometry
  localparam int IFQ_DEPTH = 4;
  localparam int IFQ_AW    = 32;
  localparam int IFQ_DW    = 32;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of {word address, instruction}; head is read straight from storage.
// Latency: a push is visible at the head the cycle after the push edge; no output register.
// Backpressure: caller never pushes when full; pop is ignored when empty; flush empties the queue.
// Ports: clk, reset (async, active-high), i_push/i_push_addr/i_push_data, i_pop, i_flush,
//        o_count (occupancy), o_head_vld/o_head_addr/o_head_data (current head entry).
module ifetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW,
  parameter int DW    = IFQ_DW,
  parameter int CW    = $clog2(IFQ_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_addr,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic          o_head_vld,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_addr_mem [DEPTH];
  logic [DW-1:0] r_data_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop = i_pop & (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_mem[i] <= '0;
        r_data_mem[i] <= '0;
      end
    end else if (i_flush) begin
      // Flush wins over any same-cycle push or pop.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_addr_mem[r_wr_ptr] <= i_push_addr;
        r_data_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + {{(CW-1){1'b0}}, i_push} - {{(CW-1){1'b0}}, w_pop};
    end
  end

  assign o_count     = r_count;
  assign o_head_vld  = (r_count != '0);
  assign o_head_addr = r_addr_mem[r_rd_ptr];
  assign o_head_data = r_data_mem[r_rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch: word-address pointer, single-outstanding req/ack reads, queue to decode.
// Latency: ack at edge N -> inst_valid in cycle N+1; zero-wait memory sustains one word per cycle.
// Backpressure: stops issuing when the queue is full; redirect flushes and drops the in-flight reply.
// Ports: clk, reset (async, active-high), redirect/redirect_addr (branch reload),
//        mem_req/mem_addr/mem_ack/mem_rdata (memory), inst_valid/inst_ready/inst_data/inst_addr (decode).
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW,
  parameter int DW    = IFQ_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_addr
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  logic [1:0]    r_state;
  logic [AW-1:0] r_fptr;
  logic [AW-1:0] r_req_addr;

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  logic          w_push;
  logic          w_pop;

  // A redirect suppresses both push and pop; the flush takes care of occupancy.
  assign w_push = (r_state == IFQ_FETCH) & mem_ack & ~redirect;
  assign w_pop  = inst_valid & inst_ready & ~redirect;

  // Occupancy after this cycle's push/pop, used to decide on back-to-back issue.
  assign w_count_next = w_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .CW    (CW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_addr (r_req_addr),
    .i_push_data (mem_rdata),
    .i_pop       (w_pop),
    .i_flush     (redirect),
    .o_count     (w_count),
    .o_head_vld  (inst_valid),
    .o_head_addr (inst_addr),
    .o_head_data (inst_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IFQ_IDLE;
      r_fptr     <= '0;
      r_req_addr <= '0;
    end else begin
      case (r_state)
        IFQ_IDLE: begin
          if (redirect) begin
            r_fptr     <= redirect_addr;
            r_req_addr <= redirect_addr;
            r_state    <= IFQ_FETCH;
          end else if (w_count < LP_DEPTH) begin
            r_req_addr <= r_fptr;
            r_state    <= IFQ_FETCH;
          end
        end
        IFQ_FETCH: begin
          if (redirect) begin
            r_fptr <= redirect_addr;
            if (mem_ack) begin
              // Reply is dropped and the new target issues with no idle cycle.
              r_req_addr <= redirect_addr;
            end else begin
              // The request cannot be withdrawn; keep it up and drop its reply.
              r_state <= IFQ_DISCARD;
            end
          end else if (mem_ack) begin
            r_fptr <= r_req_addr + AW'(1);
            if (w_count_next < LP_DEPTH) begin
              r_req_addr <= r_req_addr + AW'(1);
            end else begin
              r_state <= IFQ_IDLE;
            end
          end
        end
        IFQ_DISCARD: begin
          if (redirect) begin
            r_fptr <= redirect_addr;
          end
          if (mem_ack) begin
            // A redirect landing on the ack cycle is the newest target.
            r_req_addr <= redirect ? redirect_addr : r_fptr;
            r_state    <= IFQ_FETCH;
          end
        end
        default: r_state <= IFQ_IDLE;
      endcase
    end
  end

  assign mem_req  = (r_state == IFQ_FETCH) | (r_state == IFQ_DISCARD);
  assign mem_addr = r_req_addr;

endmodule
